// File: rtl/cache_arbiter_pkg.sv
// Shared types for the L1 miss arbiter: FSM states, grant ids and the
// packed master-side request bundle that the output mux steers.
package cache_arbiter_types;

    localparam int SEL_W = 16;
    localparam int ADR_W = 12;
    localparam int DAT_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    typedef struct packed {
        logic             cyc;
        logic             stb;
        logic             we;
        logic [SEL_W-1:0] sel;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
    } wb_req_t;

    localparam int REQ_W = $bits(wb_req_t);

endpackage

// File: rtl/generic_mux.sv
// Generic N-way one-hot-free mux: purely combinational, zero latency.
// An out-of-range select yields all zeros.
module generic_mux #(
    parameter int WIDTH = 1,
    parameter int N     = 2,
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0][WIDTH-1:0] din,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        dout
);

    always_comb begin
        dout = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) dout = din[i];
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates icache/dcache Wishbone miss traffic onto one L2 master port.
// Grant takes one IDLE cycle; ACK/RTY/DAT_S pass back with zero added latency.
module cache_arbiter
    import cache_arbiter_types::*;
#(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             icache_cyc,
    input  logic             icache_stb,
    input  logic             icache_we,
    input  logic [SEL_W-1:0] icache_sel,
    input  logic [ADR_W-1:0] icache_adr,
    input  logic [DAT_W-1:0] icache_dat_m,
    output logic [DAT_W-1:0] icache_dat_s,
    output logic             icache_ack,
    output logic             icache_rty,
    input  logic             dcache_cyc,
    input  logic             dcache_stb,
    input  logic             dcache_we,
    input  logic [SEL_W-1:0] dcache_sel,
    input  logic [ADR_W-1:0] dcache_adr,
    input  logic [DAT_W-1:0] dcache_dat_m,
    output logic [DAT_W-1:0] dcache_dat_s,
    output logic             dcache_ack,
    output logic             dcache_rty,
    output logic             out_clk,
    output logic             out_cyc,
    output logic             out_stb,
    output logic             out_we,
    output logic [SEL_W-1:0] out_sel,
    output logic [ADR_W-1:0] out_adr,
    output logic [DAT_W-1:0] out_dat_m,
    input  logic [DAT_W-1:0] out_dat_s,
    input  logic             out_ack,
    input  logic             out_rty,
    output logic             debug_grant_i,
    output logic             debug_grant_d
);

    state_t state_q, state_d;
    grant_t last_q, last_d;
    logic   blk_i_q, blk_i_d;
    logic   blk_d_q, blk_d_d;
    logic   gnt_i, gnt_d;
    logic   req_i, req_d, done;

    // A port that just completed sits out one IDLE cycle so the other side gets a turn.
    assign req_i = icache_cyc & icache_stb & ~blk_i_q;
    assign req_d = dcache_cyc & dcache_stb & ~blk_d_q;
    assign done  = out_ack | out_rty;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        blk_i_d = 1'b0;
        blk_d_d = 1'b0;
        gnt_i   = 1'b0;
        gnt_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_d && (!req_i || FIXED_PRIORITY || last_q == GNT_I)) begin
                    gnt_d   = 1'b1;
                    state_d = ST_SERVE_D;
                    last_d  = GNT_D;
                end else if (req_i) begin
                    gnt_i   = 1'b1;
                    state_d = ST_SERVE_I;
                    last_d  = GNT_I;
                end
            end
            ST_SERVE_I: begin
                if (done) begin
                    state_d = ST_IDLE;
                    blk_i_d = 1'b1;
                end else if (!icache_cyc) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVE_D: begin
                if (done) begin
                    state_d = ST_IDLE;
                    blk_d_d = 1'b1;
                end else if (!dcache_cyc) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= GNT_I;
            blk_i_q <= 1'b0;
            blk_d_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            blk_i_q <= blk_i_d;
            blk_d_q <= blk_d_d;
        end
    end

    // Select 0 (all-zero bundle) covers both IDLE and the reset cycle.
    logic [1:0]            mux_sel;
    logic [2:0][REQ_W-1:0] mux_din;
    logic [REQ_W-1:0]      mux_dout;
    wb_req_t               out_req;

    always_comb begin
        mux_sel = 2'd0;
        if (!rst) begin
            case (state_q)
                ST_SERVE_I: mux_sel = 2'd1;
                ST_SERVE_D: mux_sel = 2'd2;
                default:    mux_sel = 2'd0;
            endcase
        end
    end

    assign mux_din[0] = '0;
    assign mux_din[1] = {icache_cyc, icache_stb, icache_we, icache_sel, icache_adr, icache_dat_m};
    assign mux_din[2] = {dcache_cyc, dcache_stb, dcache_we, dcache_sel, dcache_adr, dcache_dat_m};

    generic_mux #(.WIDTH(REQ_W), .N(3)) u_req_mux (
        .din  (mux_din),
        .sel  (mux_sel),
        .dout (mux_dout)
    );

    assign out_req   = wb_req_t'(mux_dout);
    assign out_clk   = clk;
    assign out_cyc   = out_req.cyc;
    assign out_stb   = out_req.stb;
    assign out_we    = out_req.we;
    assign out_sel   = out_req.sel;
    assign out_adr   = out_req.adr;
    assign out_dat_m = out_req.dat;

    assign icache_ack    = (mux_sel == 2'd1) & out_ack;
    assign icache_rty    = (mux_sel == 2'd1) & out_rty;
    assign dcache_ack    = (mux_sel == 2'd2) & out_ack;
    assign dcache_rty    = (mux_sel == 2'd2) & out_rty;
    assign icache_dat_s  = out_dat_s;
    assign dcache_dat_s  = out_dat_s;
    assign debug_grant_i = gnt_i & ~rst;
    assign debug_grant_d = gnt_d & ~rst;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: a per-cycle vector table on a round-robin
// instance, then hand sequences for single-port latency and fixed priority.
module tb_cache_arbiter;
    import cache_arbiter_types::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst [2];
    logic              i_cyc, i_we, d_cyc, d_we;
    logic [SEL_W-1:0]  i_sel, d_sel;
    logic [ADR_W-1:0]  i_adr, d_adr;
    logic [DAT_W-1:0]  i_datm, d_datm, dn_dat_s;
    logic              dn_ack, dn_rty;

    logic [DAT_W-1:0]  i_dat_s [2];
    logic [DAT_W-1:0]  d_dat_s [2];
    logic              i_ack [2], i_rty [2], d_ack [2], d_rty [2];
    logic              o_clk [2], o_cyc [2], o_stb [2], o_we [2];
    logic [SEL_W-1:0]  o_sel [2];
    logic [ADR_W-1:0]  o_adr [2];
    logic [DAT_W-1:0]  o_datm [2];
    logic              gi [2], gd [2];

    cache_arbiter #(.FIXED_PRIORITY(1'b0)) dut_rr (
        .clk(clk), .rst(rst[0]),
        .icache_cyc(i_cyc), .icache_stb(i_cyc), .icache_we(i_we), .icache_sel(i_sel),
        .icache_adr(i_adr), .icache_dat_m(i_datm), .icache_dat_s(i_dat_s[0]),
        .icache_ack(i_ack[0]), .icache_rty(i_rty[0]),
        .dcache_cyc(d_cyc), .dcache_stb(d_cyc), .dcache_we(d_we), .dcache_sel(d_sel),
        .dcache_adr(d_adr), .dcache_dat_m(d_datm), .dcache_dat_s(d_dat_s[0]),
        .dcache_ack(d_ack[0]), .dcache_rty(d_rty[0]),
        .out_clk(o_clk[0]), .out_cyc(o_cyc[0]), .out_stb(o_stb[0]), .out_we(o_we[0]),
        .out_sel(o_sel[0]), .out_adr(o_adr[0]), .out_dat_m(o_datm[0]),
        .out_dat_s(dn_dat_s), .out_ack(dn_ack), .out_rty(dn_rty),
        .debug_grant_i(gi[0]), .debug_grant_d(gd[0])
    );

    cache_arbiter #(.FIXED_PRIORITY(1'b1)) dut_fp (
        .clk(clk), .rst(rst[1]),
        .icache_cyc(i_cyc), .icache_stb(i_cyc), .icache_we(i_we), .icache_sel(i_sel),
        .icache_adr(i_adr), .icache_dat_m(i_datm), .icache_dat_s(i_dat_s[1]),
        .icache_ack(i_ack[1]), .icache_rty(i_rty[1]),
        .dcache_cyc(d_cyc), .dcache_stb(d_cyc), .dcache_we(d_we), .dcache_sel(d_sel),
        .dcache_adr(d_adr), .dcache_dat_m(d_datm), .dcache_dat_s(d_dat_s[1]),
        .dcache_ack(d_ack[1]), .dcache_rty(d_rty[1]),
        .out_clk(o_clk[1]), .out_cyc(o_cyc[1]), .out_stb(o_stb[1]), .out_we(o_we[1]),
        .out_sel(o_sel[1]), .out_adr(o_adr[1]), .out_dat_m(o_datm[1]),
        .out_dat_s(dn_dat_s), .out_ack(dn_ack), .out_rty(dn_rty),
        .debug_grant_i(gi[1]), .debug_grant_d(gd[1])
    );

    typedef struct {
        logic             rst, ic, dc, ack, rty;
        logic             ocyc, owe;
        logic [ADR_W-1:0] oadr;
        logic             iack, dack, irty, drty, egi, egd;
    } vec_t;

    vec_t tbl [22];
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [DAT_W-1:0] I_DAT = {4{32'h1111_1111}};
    localparam logic [DAT_W-1:0] D_DAT = {4{32'h2222_2222}};
    localparam logic [DAT_W-1:0] BIG   = 128'hDEAD0000_00000000_00000000_0000BEEF;

    function automatic vec_t mk(input logic r, ic, dc, ack, rty, ocyc, owe,
                                input logic [ADR_W-1:0] oadr,
                                input logic iack, dack, irty, drty, egi, egd);
        vec_t v;
        v.rst = r; v.ic = ic; v.dc = dc; v.ack = ack; v.rty = rty;
        v.ocyc = ocyc; v.owe = owe; v.oadr = oadr;
        v.iack = iack; v.dack = dack; v.irty = irty; v.drty = drty;
        v.egi = egi; v.egd = egd;
        return v;
    endfunction

    function automatic logic [20:0] obs(input int u);
        return {o_cyc[u], o_stb[u], o_we[u], o_adr[u], i_ack[u], d_ack[u],
                i_rty[u], d_rty[u], gi[u], gd[u]};
    endfunction

    task automatic chk(input string nm, input logic [DAT_W-1:0] act, input logic [DAT_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                 rst ic dc ack rty  ocyc we  adr      iack dack irty drty gi gd
        tbl[0]  = mk(1, 1, 1, 1, 0,  0, 0, 12'h000,  0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 1, 0, 0,  0, 0, 12'h000,  0, 0, 0, 0, 0, 1);
        tbl[2]  = mk(0, 1, 1, 0, 0,  1, 1, 12'h020,  0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 1, 1, 0,  1, 1, 12'h020,  0, 1, 0, 0, 0, 0);
        tbl[4]  = mk(0, 1, 1, 0, 0,  0, 0, 12'h000,  0, 0, 0, 0, 1, 0);
        tbl[5]  = mk(0, 1, 1, 1, 0,  1, 0, 12'h010,  1, 0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 1, 0, 0,  0, 0, 12'h000,  0, 0, 0, 0, 0, 1);
        tbl[7]  = mk(0, 1, 1, 1, 0,  1, 1, 12'h020,  0, 1, 0, 0, 0, 0);
        tbl[8]  = mk(0, 1, 1, 0, 0,  0, 0, 12'h000,  0, 0, 0, 0, 1, 0);
        tbl[9]  = mk(0, 1, 1, 1, 0,  1, 0, 12'h010,  1, 0, 0, 0, 0, 0);
        tbl[10] = mk(0, 0, 1, 0, 0,  0, 0, 12'h000,  0, 0, 0, 0, 0, 1);
        tbl[11] = mk(0, 0, 1, 0, 1,  1, 1, 12'h020,  0, 0, 0, 1, 0, 0);
        tbl[12] = mk(0, 0, 1, 0, 0,  0, 0, 12'h000,  0, 0, 0, 0, 0, 0);
        tbl[13] = mk(0, 0, 1, 0, 0,  0, 0, 12'h000,  0, 0, 0, 0, 0, 1);
        tbl[14] = mk(0, 1, 1, 0, 0,  1, 1, 12'h020,  0, 0, 0, 0, 0, 0);
        tbl[15] = mk(0, 1, 0, 0, 0,  0, 1, 12'h020,  0, 0, 0, 0, 0, 0);
        tbl[16] = mk(0, 1, 0, 0, 0,  0, 0, 12'h000,  0, 0, 0, 0, 1, 0);
        tbl[17] = mk(0, 1, 0, 0, 0,  1, 0, 12'h010,  0, 0, 0, 0, 0, 0);
        tbl[18] = mk(1, 1, 0, 1, 0,  0, 0, 12'h000,  0, 0, 0, 0, 0, 0);
        tbl[19] = mk(0, 1, 1, 0, 0,  0, 0, 12'h000,  0, 0, 0, 0, 0, 1);
        tbl[20] = mk(0, 1, 1, 1, 0,  1, 1, 12'h020,  0, 1, 0, 0, 0, 0);
        tbl[21] = mk(0, 0, 0, 1, 0,  0, 0, 12'h000,  0, 0, 0, 0, 0, 0);

        rst[0] = 1'b1; rst[1] = 1'b1;
        i_cyc = 1'b0; i_we = 1'b0; i_sel = 16'hFFFF; i_adr = 12'h010; i_datm = I_DAT;
        d_cyc = 1'b0; d_we = 1'b1; d_sel = 16'h00FF; d_adr = 12'h020; d_datm = D_DAT;
        dn_ack = 1'b0; dn_rty = 1'b0; dn_dat_s = '0;
        repeat (2) step();

        // Round-robin instance, one table row per clock.
        for (int k = 0; k < 22; k++) begin
            rst[0] = tbl[k].rst;
            i_cyc  = tbl[k].ic;
            d_cyc  = tbl[k].dc;
            dn_ack = tbl[k].ack;
            dn_rty = tbl[k].rty;
            @(negedge clk);
            chk($sformatf("vec%0d", k), {107'b0, obs(0)},
                {107'b0, tbl[k].ocyc, tbl[k].ocyc, tbl[k].owe, tbl[k].oadr,
                 tbl[k].iack, tbl[k].dack, tbl[k].irty, tbl[k].drty, tbl[k].egi, tbl[k].egd});
            step();
        end

        // Lone icache read, downstream ACK three cycles after the request.
        dn_ack = 1'b0; i_adr = 12'h0A4; i_cyc = 1'b1; d_cyc = 1'b0;
        @(negedge clk);
        chk("rd_t0_grant", {126'b0, gi[0], o_cyc[0]}, 128'b10);
        step();
        @(negedge clk);
        chk("rd_t1_cyc_adr", {115'b0, o_cyc[0], o_adr[0]}, {115'b0, 1'b1, 12'h0A4});
        chk("rd_t1_sel", {112'b0, o_sel[0]}, {112'b0, 16'hFFFF});
        chk("rd_t1_datm", o_datm[0], I_DAT);
        chk("rd_t1_clk", {127'b0, o_clk[0]}, 128'b0);
        step();
        @(negedge clk);
        chk("rd_t2_noack", {126'b0, i_ack[0], d_ack[0]}, 128'b0);
        step();
        dn_ack = 1'b1; dn_dat_s = BIG;
        @(negedge clk);
        chk("rd_t3_acks", {126'b0, i_ack[0], d_ack[0]}, 128'b10);
        chk("rd_t3_idat", i_dat_s[0], BIG);
        chk("rd_t3_ddat", d_dat_s[0], BIG);
        step();
        dn_ack = 1'b0; i_cyc = 1'b0; i_adr = 12'h010;
        @(negedge clk);
        chk("rd_t4_idle", {126'b0, o_cyc[0], i_ack[0]}, 128'b0);
        step();

        // Fixed-priority instance: dcache wins every tie, even right after its own grant.
        rst[0] = 1'b1; rst[1] = 1'b1;
        step();
        rst[1] = 1'b0;
        dn_dat_s = D_DAT;
        for (int t = 0; t < 3; t++) begin
            i_cyc = 1'b1; d_cyc = 1'b1; dn_ack = 1'b0;
            @(negedge clk);
            chk($sformatf("fp_tie%0d", t), {126'b0, gi[1], gd[1]}, 128'b01);
            step();
            dn_ack = 1'b1;
            @(negedge clk);
            chk($sformatf("fp_ack%0d", t), {113'b0, i_ack[1], d_ack[1], o_we[1], o_adr[1]},
                {113'b0, 1'b0, 1'b1, 1'b1, 12'h020});
            chk($sformatf("fp_wdat%0d", t), o_datm[1], D_DAT);
            step();
            dn_ack = 1'b0; i_cyc = 1'b0;
            @(negedge clk);
            chk($sformatf("fp_guard%0d", t), {126'b0, gi[1], gd[1]}, 128'b00);
            step();
        end
        d_cyc = 1'b0; i_cyc = 1'b1;
        @(negedge clk);
        chk("fp_icache_grant", {126'b0, gi[1], gd[1]}, 128'b10);
        step();
        dn_ack = 1'b1;
        @(negedge clk);
        chk("fp_icache_ack", {114'b0, i_ack[1], d_ack[1], o_adr[1]}, {114'b0, 2'b10, 12'h010});
        chk("fp_sel", {112'b0, o_sel[1]}, {112'b0, 16'hFFFF});
        chk("fp_bcast", {i_dat_s[1] ^ d_dat_s[1]}, 128'b0);
        chk("fp_ddat", d_dat_s[1], D_DAT);
        chk("fp_rty_clk", {125'b0, i_rty[1], d_rty[1], o_clk[1]}, 128'b0);
        step();
        dn_ack = 1'b0; i_cyc = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
